// File: rtl/ddfs_pkg.sv
// Shared types and constants for the DDFS note sequencer and its DDFS consumer.
package ddfs_pkg;

  localparam int PHASE_WIDTH = 30;
  localparam int ENV_WIDTH   = 16;
  localparam int DUR_WIDTH   = 16;
  localparam int NOTE_AW     = 4;
  localparam int NOTE_DEPTH  = 16;

  localparam logic [ENV_WIDTH-1:0] ENV_ONE = 16'h4000;

  typedef struct packed {
    logic [PHASE_WIDTH-1:0] fccw;
    logic [DUR_WIDTH-1:0]   dur;
  } note_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ATTACK  = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } seq_state_t;

  // Index of the last note in a pass; a length of 0 plays one note, lengths above 16 play all 16.
  function automatic logic [NOTE_AW-1:0] last_idx(input logic [4:0] len);
    if (len == 5'd0) return '0;
    if (len >= 5'd16) return '1;
    return len[NOTE_AW-1:0] - 4'd1;
  endfunction

endpackage

// File: rtl/ddfs_seq_tick_gen.sv
// tick_gen: free-running mod-DIV divider producing a registered one-cycle tick.
// i_clr restarts the count so the first tick lands DIV+1 cycles after the clear.
module tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = r_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
    end
  end

endmodule

// File: rtl/ddfs_seq.sv
// ddfs_seq: plays a 16-entry note table into a DDFS as fccw plus an attack/sustain/release envelope.
// Define DDFS_SEQ_LOOP_EN to honour the loop input; without it the sequence ends after one pass.
module ddfs_seq
  import ddfs_pkg::*;
#(
  parameter int                   TICK_DIV = 100000,
  parameter logic [ENV_WIDTH-1:0] ATK_STEP = 16'h0400,
  parameter logic [ENV_WIDTH-1:0] REL_STEP = 16'h0200
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [NOTE_AW-1:0]     wr_addr,
  input  logic [PHASE_WIDTH-1:0] wr_fccw,
  input  logic [DUR_WIDTH-1:0]   wr_dur,
  input  logic [4:0]             seq_len,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  output logic [PHASE_WIDTH-1:0] fccw,
  output logic [ENV_WIDTH-1:0]   env,
  output logic                   busy,
  output logic [NOTE_AW-1:0]     note_idx,
  output logic                   done,
  output seq_state_t             dbg_state
);

  note_t                  r_table [NOTE_DEPTH];
  note_t                  r_rd;
  seq_state_t             r_state, w_state_nxt;
  logic [PHASE_WIDTH-1:0] r_fccw, w_fccw_nxt;
  logic [ENV_WIDTH-1:0]   r_env, w_env_nxt, w_env_up, w_env_dn;
  logic [ENV_WIDTH:0]     w_env_sum;
  logic [NOTE_AW-1:0]     r_note_idx, w_idx_nxt, w_last_idx;
  logic [DUR_WIDTH-1:0]   r_dur, w_dur_nxt, r_dur_cnt, w_dur_cnt_nxt, w_dur_inc;
  logic                   r_busy, r_done, w_done_nxt;
  logic                   r_stop_lat, w_stop_lat_nxt;
  logic                   w_go_idle, w_tick, w_tick_clr, w_loop;

`ifdef DDFS_SEQ_LOOP_EN
  assign w_loop = loop;
`else
  logic w_unused_loop;
  assign w_loop        = 1'b0;
  assign w_unused_loop = loop;
`endif

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_tick_clr),
    .o_tick  (w_tick)
  );

  // Table read is addressed by the next index so LOAD finds its entry already registered.
  always_ff @(posedge clk) begin
    if (wr_en) r_table[wr_addr] <= note_t'{fccw: wr_fccw, dur: wr_dur};
    r_rd <= r_table[w_idx_nxt];
  end

  assign w_env_sum  = {1'b0, r_env} + {1'b0, ATK_STEP};
  assign w_env_up   = (w_env_sum >= {1'b0, ENV_ONE}) ? ENV_ONE : w_env_sum[ENV_WIDTH-1:0];
  assign w_env_dn   = (r_env > REL_STEP) ? (r_env - REL_STEP) : '0;
  assign w_dur_inc  = r_dur_cnt + 16'd1;
  assign w_last_idx = last_idx(seq_len);

  always_comb begin
    w_state_nxt    = r_state;
    w_fccw_nxt     = r_fccw;
    w_env_nxt      = r_env;
    w_idx_nxt      = r_note_idx;
    w_dur_nxt      = r_dur;
    w_dur_cnt_nxt  = r_dur_cnt;
    w_stop_lat_nxt = r_stop_lat;
    w_done_nxt     = 1'b0;
    w_go_idle      = 1'b0;
    w_tick_clr     = 1'b0;

    case (r_state)
      IDLE: begin
        w_stop_lat_nxt = 1'b0;
        if (start && !stop) begin
          w_idx_nxt   = '0;
          w_state_nxt = LOAD;
        end
      end

      LOAD: begin
        w_tick_clr    = 1'b1;
        w_dur_cnt_nxt = '0;
        if (stop || (r_rd.dur == '0)) begin
          w_go_idle = 1'b1;
        end else begin
          w_fccw_nxt  = r_rd.fccw;
          w_env_nxt   = '0;
          w_dur_nxt   = r_rd.dur;
          w_state_nxt = ATTACK;
        end
      end

      ATTACK: begin
        if (stop) begin
          w_stop_lat_nxt = 1'b1;
          w_state_nxt    = RELEASE;
        end else if (w_tick) begin
          // Duration expiry wins over reaching full scale on the same tick.
          w_env_nxt     = w_env_up;
          w_dur_cnt_nxt = w_dur_inc;
          if (w_dur_inc == r_dur)       w_state_nxt = RELEASE;
          else if (w_env_up == ENV_ONE) w_state_nxt = SUSTAIN;
        end
      end

      SUSTAIN: begin
        if (stop) begin
          w_stop_lat_nxt = 1'b1;
          w_state_nxt    = RELEASE;
        end else if (w_tick) begin
          w_dur_cnt_nxt = w_dur_inc;
          if (w_dur_inc == r_dur) w_state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        if (stop) w_stop_lat_nxt = 1'b1;
        if (r_env == '0) begin
          if (r_stop_lat || stop) begin
            w_go_idle = 1'b1;
          end else if (r_note_idx < w_last_idx) begin
            w_idx_nxt   = r_note_idx + 4'd1;
            w_state_nxt = LOAD;
          end else if (w_loop) begin
            w_idx_nxt   = '0;
            w_state_nxt = LOAD;
          end else begin
            w_go_idle = 1'b1;
          end
        end else if (w_tick) begin
          w_env_nxt = w_env_dn;
        end
      end

      default: w_go_idle = 1'b1;
    endcase

    if (w_go_idle) begin
      w_state_nxt    = IDLE;
      w_fccw_nxt     = '0;
      w_env_nxt      = '0;
      w_stop_lat_nxt = 1'b0;
      w_done_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_fccw     <= '0;
      r_env      <= '0;
      r_note_idx <= '0;
      r_dur      <= '0;
      r_dur_cnt  <= '0;
      r_stop_lat <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fccw     <= w_fccw_nxt;
      r_env      <= w_env_nxt;
      r_note_idx <= w_idx_nxt;
      r_dur      <= w_dur_nxt;
      r_dur_cnt  <= w_dur_cnt_nxt;
      r_stop_lat <= w_stop_lat_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign fccw      = r_fccw;
  assign env       = r_env;
  assign busy      = r_busy;
  assign note_idx  = r_note_idx;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ddfs_seq.sv
// Directed bench for ddfs_seq with TICK_DIV=4; loop expectations follow DDFS_SEQ_LOOP_EN.
module tb_ddfs_seq;
  import ddfs_pkg::*;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [29:0] wr_fccw = '0;
  logic [15:0] wr_dur = '0;
  logic [4:0]  seq_len = 5'd1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [29:0] fccw;
  logic [15:0] env;
  logic        busy;
  logic [3:0]  note_idx;
  logic        done;
  seq_state_t  dbg_state;

  always #5 clk = ~clk;

  ddfs_seq #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_fccw(wr_fccw), .wr_dur(wr_dur), .seq_len(seq_len), .start(start),
    .stop(stop), .loop(loop), .fccw(fccw), .env(env), .busy(busy),
    .note_idx(note_idx), .done(done), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int env_err = 0;
  int cyc;
  seq_state_t  prev_state = IDLE;
  logic [15:0] prev_env = '0;
  logic [3:0]  got_idx_q[$];
  logic [29:0] got_fccw_q[$];
  logic [29:0] exp_q[$];
  logic [3:0]  exp_idx_q[$];

  function automatic logic [15:0] env_up(input logic [15:0] e);
    return (e >= 16'h3C00) ? 16'h4000 : e + 16'h0400;
  endfunction

  function automatic logic [15:0] env_dn(input logic [15:0] e);
    return (e > 16'h0200) ? e - 16'h0200 : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: records each note as it starts and checks every envelope step against the model.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dbg_state == ATTACK && prev_state == LOAD) begin
      got_idx_q.push_back(note_idx);
      got_fccw_q.push_back(fccw);
    end
    if (dbg_state == ATTACK && prev_state == ATTACK && env != prev_env && env != env_up(prev_env))
      env_err++;
    if (dbg_state == SUSTAIN && env != 16'h4000) env_err++;
    if (dbg_state == RELEASE && prev_state == RELEASE && env != prev_env && env != env_dn(prev_env))
      env_err++;
    prev_state = dbg_state;
    prev_env   = env;
  end

  task automatic write_note(input logic [3:0] a, input logic [29:0] f, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_fccw = f; wr_dur = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    done_cnt = 0;
    got_idx_q.delete();
    got_fccw_q.delete();
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic wait_state(input seq_state_t s, input int limit, output int c);
    c = 0;
    while (dbg_state != s && c < limit) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_env_zero(input int limit, output int c);
    c = 0;
    while (env != 16'h0 && c < limit) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic compare_notes(input string tag);
    chk({tag, "_count"}, got_fccw_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_fccw_q.size() > 0) begin
      chk({tag, "_fccw"}, got_fccw_q.pop_front(), exp_q.pop_front());
      chk({tag, "_idx"}, got_idx_q.pop_front(), exp_idx_q.pop_front());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fccw", fccw, 30'h0);
    chk("rst_env", env, 16'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", note_idx, 4'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full note: 16 attack ticks, sustain to 40 ticks, 32 release ticks.
    write_note(4'd0, 30'd4295, 16'd40);
    seq_len = 5'd1; loop = 1'b0;
    clear_mon();
    pulse_start();
    chk("load_busy", busy, 1'b1);
    @(negedge clk);
    chk("n26_fccw", fccw, 30'd4295);
    chk("n26_env0", env, 16'h0);
    chk("n26_attack", dbg_state, ATTACK);
    wait_state(SUSTAIN, 200, cyc);
    chk("n26_atk_cyc", cyc, 65);
    chk("n26_env_full", env, 16'h4000);
    wait_state(RELEASE, 200, cyc);
    chk("n26_sus_cyc", cyc, 96);
    wait_env_zero(300, cyc);
    chk("n26_rel_cyc", cyc, 128);
    wait_state(IDLE, 10, cyc);
    chk("n26_idle_cyc", cyc, 1);
    chk("n26_done", done, 1'b1);
    chk("n26_fccw0", fccw, 30'h0);
    chk("n26_busy0", busy, 1'b0);
    @(negedge clk);
    chk("n26_done_low", done, 1'b0);
    chk("n26_done_cnt", done_cnt, 1);

    // Short note: release starts from attack at env 1400h.
    write_note(4'd0, 30'h77, 16'd5);
    clear_mon();
    pulse_start();
    @(negedge clk);
    wait_state(RELEASE, 100, cyc);
    chk("n27_rel_cyc", cyc, 21);
    chk("n27_env", env, 16'h1400);
    wait_env_zero(100, cyc);
    chk("n27_ramp_cyc", cyc, 40);
    wait_state(IDLE, 10, cyc);
    chk("n27_idle", dbg_state, IDLE);
    @(negedge clk);
    chk("n27_done_cnt", done_cnt, 1);

    // Three-note sequence, with and without looping.
    write_note(4'd0, 30'h111, 16'd2);
    write_note(4'd1, 30'h222, 16'd2);
    write_note(4'd2, 30'h333, 16'd2);
    seq_len = 5'd3; loop = 1'b1;
    clear_mon();
    pulse_start();
`ifdef DDFS_SEQ_LOOP_EN
    cyc = 0;
    while (got_idx_q.size() < 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    pulse_stop();
    wait_state(IDLE, 100, cyc);
    chk("n28_idle", dbg_state, IDLE);
    repeat (20) @(negedge clk);
    exp_q = '{30'h111, 30'h222, 30'h333, 30'h111, 30'h222};
    exp_idx_q = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
`else
    wait_state(IDLE, 500, cyc);
    chk("n28_idle", dbg_state, IDLE);
    repeat (20) @(negedge clk);
    exp_q = '{30'h111, 30'h222, 30'h333};
    exp_idx_q = '{4'd0, 4'd1, 4'd2};
`endif
    chk("n28_busy", busy, 1'b0);
    chk("n28_done_cnt", done_cnt, 1);
    compare_notes("n28");
    loop = 1'b0;

    // Zero-duration entry ends the sequence after note 0.
    write_note(4'd0, 30'h100, 16'd2);
    write_note(4'd1, 30'h200, 16'd0);
    seq_len = 5'd4;
    clear_mon();
    pulse_start();
    wait_state(IDLE, 200, cyc);
    chk("n29_idle", dbg_state, IDLE);
    repeat (3) @(negedge clk);
    chk("n29_done_cnt", done_cnt, 1);
    exp_q = '{30'h100};
    exp_idx_q = '{4'd0};
    compare_notes("n29");

    // start and stop together stay idle.
    clear_mon();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 1'b0);
    @(negedge clk);
    chk("ss_state", dbg_state, IDLE);
    chk("ss_done", done_cnt, 0);

    // start while busy is ignored; async reset mid-sustain; table survives reset.
    write_note(4'd0, 30'd123, 16'd40);
    seq_len = 5'd1;
    clear_mon();
    pulse_start();
    wait_state(SUSTAIN, 200, cyc);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("busy_start_state", dbg_state, SUSTAIN);
    chk("busy_start_notes", got_idx_q.size(), 1);
    reset_n = 1'b0;
    #1;
    chk("async_env", env, 16'h0);
    chk("async_busy", busy, 1'b0);
    chk("async_state", dbg_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    pulse_start();
    @(negedge clk);
    chk("table_kept", fccw, 30'd123);
    pulse_stop();
    wait_state(IDLE, 100, cyc);
    chk("stop_atk_idle", dbg_state, IDLE);
    @(negedge clk);
    chk("stop_atk_done", done_cnt, 1);

    // Entry 1 rewritten while note 0 plays.
    write_note(4'd0, 30'hAAA, 16'd3);
    write_note(4'd1, 30'hBBB, 16'd3);
    seq_len = 5'd2;
    clear_mon();
    pulse_start();
    @(negedge clk);
    write_note(4'd1, 30'hCCC, 16'd3);
    wait_state(IDLE, 300, cyc);
    chk("n31_idle", dbg_state, IDLE);
    @(negedge clk);
    exp_q = '{30'hAAA, 30'hCCC};
    exp_idx_q = '{4'd0, 4'd1};
    compare_notes("n31");

    // stop during release is latched and ends the sequence after note 0.
    clear_mon();
    pulse_start();
    wait_state(RELEASE, 100, cyc);
    pulse_stop();
    wait_state(IDLE, 100, cyc);
    chk("stop_rel_idle", dbg_state, IDLE);
    @(negedge clk);
    chk("stop_rel_notes", got_idx_q.size(), 1);
    chk("stop_rel_done", done_cnt, 1);

    // stop during LOAD returns straight to idle.
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_load_state", dbg_state, IDLE);
    chk("stop_load_done", done, 1'b1);
    chk("stop_load_notes", got_idx_q.size(), 0);

    // seq_len of 0 plays a single note.
    write_note(4'd0, 30'h500, 16'd1);
    seq_len = 5'd0;
    clear_mon();
    pulse_start();
    wait_state(IDLE, 100, cyc);
    chk("len0_idle", dbg_state, IDLE);
    @(negedge clk);
    chk("len0_done", done_cnt, 1);
    exp_q = '{30'h500};
    exp_idx_q = '{4'd0};
    compare_notes("len0");

    chk("env_model", env_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddfs_seq.md
DDFS_SEQ -- requirements
Module: ddfs_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clocks per envelope/duration tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter ATK_STEP, default 16'h0400, meaning env increment per tick during attack.
REQ-003 SHALL have parameter REL_STEP, default 16'h0200, meaning env decrement per tick during release.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  note-table write strobe.
- wr_addr  in  4  table entry index.
- wr_fccw  in  30  entry frequency control word.
- wr_dur  in  16  entry duration in ticks; 0 = end marker.
- seq_len  in  5  notes per pass, 1..16; 0 treated as 1.
- start  in  1  one-cycle pulse; begins at entry 0.
- stop  in  1  one-cycle pulse; graceful abort.
- loop  in  1  restart at entry 0 after last note.
- fccw  out  30  to ddfs fccw.
- env  out  16  to ddfs env; 16'h4000 = 1.0.
- busy  out  1  high in any state except IDLE.
- note_idx  out  4  index of the note currently playing.
- done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-005 SHALL implement states IDLE, LOAD, ATTACK, SUSTAIN, RELEASE.
REQ-006 SHALL hold a 16-entry note table in registers or RAM with synchronous read; a write and a read to the same address in the same cycle SHALL return the old data.
REQ-007 SHALL accept writes in any state; a written entry SHALL take effect at its next LOAD.
REQ-008 IDLE: start=1 and stop=0 SHALL set note_idx=0 and enter LOAD on the next cycle; start while busy SHALL be ignored.
REQ-009 LOAD: one cycle; the next cycle SHALL present the entry's fccw, set env=0, clear the duration counter and enter ATTACK; a loaded dur=0 SHALL go to IDLE instead.
REQ-010 Ticks SHALL come from a free-running mod-TICK_DIV counter; the tick counter and the duration counter SHALL both be cleared at LOAD.
REQ-011 ATTACK: each tick, env SHALL become min(env+ATK_STEP, 16'h4000); on reaching 16'h4000 the block SHALL enter SUSTAIN.
REQ-012 The duration counter SHALL count ticks from note start; when it reaches dur in ATTACK or SUSTAIN, the block SHALL enter RELEASE.
REQ-013 RELEASE: each tick, env SHALL become max(env-REL_STEP, 0), with no underflow; at env=0 the block SHALL take the next-note decision.
REQ-014 Next-note decision: if note_idx < seq_len-1, increment note_idx and enter LOAD; else if loop is set, set note_idx=0 and enter LOAD; else enter IDLE.
REQ-015 stop in ATTACK/SUSTAIN SHALL enter RELEASE the next cycle; stop in RELEASE SHALL latch so that env=0 leads to IDLE; stop in LOAD SHALL go to IDLE.
REQ-016 start and stop in the same IDLE cycle: stop SHALL win and the block SHALL stay IDLE.
REQ-017 Entering IDLE from any state SHALL pulse done for one cycle and set fccw=0, env=0.
REQ-018 Every output SHALL be registered.

Reset
REQ-019 reset_n=0 SHALL asynchronously force IDLE, fccw=0, env=0, busy=0, done=0, note_idx=0, tick/duration counters=0 and the stop latch=0.
REQ-020 The note table SHALL NOT be reset.
REQ-021 Reset asserted mid-note SHALL return env to 0 immediately, with no release ramp.

Configuration
REQ-022 DDFS_SEQ_LOOP_EN defined: the loop port SHALL be honoured per REQ-014.
REQ-023 DDFS_SEQ_LOOP_EN undefined: the loop port SHALL remain present but be ignored and treated as 0, and no loop logic SHALL be synthesised.

Structure
REQ-024 Shared package ddfs_pkg SHALL hold PHASE_WIDTH=30, ENV_WIDTH=16, ENV_ONE=16'h4000, note_t {fccw, dur} and the seq_state_t enum.
REQ-025 The tick divider SHALL be sub-module tick_gen (parameter DIV; outputs a one-cycle tick).

Verification (TICK_DIV=4, defaults otherwise)
REQ-026 Entry 0 = {4295, 40}, seq_len=1, start -> fccw=4295 two cycles after start; env reaches 4000h after 16 ticks, ramps to 0 over 32 ticks; done pulses; fccw=0.
REQ-027 Entry 0 dur=5 -> RELEASE entered from ATTACK with env=1400h; env ramps down to 0 with no underflow.
REQ-028 seq_len=3, entries 0..2 distinct, loop=1 with DDFS_SEQ_LOOP_EN defined -> note_idx goes 0,1,2,0,1; stop -> release, then IDLE with done; repeated without the macro -> IDLE after index 2.
REQ-029 Entry 1 dur=0, seq_len=4 -> IDLE after note 0 releases; done pulses once.
REQ-030 start+stop in the same cycle -> busy stays 0; start while busy -> ignored; reset_n=0 mid-SUSTAIN -> env=0 and busy=0 asynchronously.
REQ-031 Write entry 1 while note 0 plays -> new fccw is used when entry 1 loads.
